// File: rtl/powlib_up_fifo_if.sv
// Stream bundle for powlib_up_fifo: narrow write side in, wide read side out.
// The flush signal exists only when UPFIFO_FLUSH_EN is defined.
interface powlib_up_fifo_if #(
  parameter int unsigned W    = 16,
  parameter int unsigned MULT = 3
);
  logic [W-1:0]      wrdata;
  logic              wrvld;
  logic              wrrdy;
  logic [W*MULT-1:0] rddata;
  logic              rdvld;
  logic              rdrdy;
`ifdef UPFIFO_FLUSH_EN
  logic              flush;

  modport slave  (input  wrdata, wrvld, rdrdy, flush, output wrrdy, rddata, rdvld);
  modport master (output wrdata, wrvld, rdrdy, flush, input  wrrdy, rddata, rdvld);
`else
  modport slave  (input  wrdata, wrvld, rdrdy, output wrrdy, rddata, rdvld);
  modport master (output wrdata, wrvld, rdrdy, input  wrrdy, rddata, rdvld);
`endif
endinterface

// File: rtl/powlib_up_fifo.sv
// Upsizing FIFO: packs MULT W-bit words (first word in the LSBs) into one W*MULT-bit word
// and queues packed words in a DEPTH-entry FIFO. EASYNC!=0 adds a registered output stage
// that counts towards the DEPTH capacity. Optional flush of a partial word is enabled by
// defining UPFIFO_FLUSH_EN.
module powlib_up_fifo #(
  parameter int unsigned W      = 16,
  parameter int unsigned MULT   = 3,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned EASYNC = 0,
  parameter int unsigned EAR    = 0,
  parameter string       ID     = "UPFIFO",
  parameter int unsigned EDBG   = 0
) (
  input  logic            clk,
  input  logic            rst,
  powlib_up_fifo_if.slave bus
);
  localparam int unsigned   OW      = W * MULT;
  localparam int unsigned   IW      = $clog2(MULT);
  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam int unsigned   CW      = PW + 1;
  localparam logic [IW-1:0] LastIdx = IW'(MULT - 1);

  logic [IW-1:0] idx_q, idx_d;
  logic [OW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;  // entries held in mem_q (excludes output register)
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          full_q, full_d;
  logic [OW-1:0] mem_q [DEPTH];

  logic          last_word, accept, push, pop_mem, out_occ_d;
  logic [OW-1:0] push_word, head_word;

  // Reset is always asynchronous; EAR is kept only for interface compatibility.
  logic unused_cfg;
  assign unused_cfg = (EAR != 0) | (ID == "");

  assign last_word = (idx_q == LastIdx);
  // full_q is registered so wrrdy never depends combinationally on rdrdy
  assign bus.wrrdy = ~last_word | ~full_q;
  assign accept    = bus.wrvld & bus.wrrdy;
  assign head_word = mem_q[rd_ptr_q];

  // Accumulate input words and form the packed word to push
  always_comb begin
    acc_d     = acc_q;
    idx_d     = idx_q;
    push      = 1'b0;
    push_word = '0;
    if (accept) begin
      if (last_word) begin
        push      = 1'b1;
        push_word = {bus.wrdata, acc_q[OW-W-1:0]};
        idx_d     = '0;
      end else begin
        acc_d[idx_q*W +: W] = bus.wrdata;
        idx_d               = idx_q + 1'b1;
      end
    end
`ifdef UPFIFO_FLUSH_EN
    // A same-cycle word is packed first; if it completed the word, flush has nothing left
    if (bus.flush && (idx_q != '0) && !full_q && !(accept && last_word)) begin
      push = 1'b1;
      for (int unsigned k = 0; k < MULT; k++) begin
        if (IW'(k) < idx_d) push_word[k*W +: W] = acc_d[k*W +: W];
      end
      idx_d = '0;
    end
`endif
  end

  // Pointer, occupancy and full-flag next state
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop_mem);
    cnt_d    = cnt_q + CW'(push) - CW'(pop_mem);
    full_d   = (({1'b0, cnt_d} + (CW+1)'(out_occ_d)) == (CW+1)'(DEPTH));
  end

  // Packed-word storage; contents are only observed through valid entries
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
    end
  end

  if (EASYNC != 0) begin : g_oreg
    logic          ovld_q, ovld_d;
    logic [OW-1:0] odata_q, odata_d;

    // Refill the output register whenever it is empty or being drained
    always_comb begin
      pop_mem = (cnt_q != '0) && (!ovld_q || bus.rdrdy);
      ovld_d  = ovld_q & ~bus.rdrdy;
      odata_d = odata_q;
      if (pop_mem) begin
        ovld_d  = 1'b1;
        odata_d = head_word;
      end
    end

    // Output register state
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ovld_q  <= 1'b0;
        odata_q <= '0;
      end else begin
        ovld_q  <= ovld_d;
        odata_q <= odata_d;
      end
    end

    assign out_occ_d  = ovld_d;
    assign bus.rdvld  = ovld_q;
    assign bus.rddata = ovld_q ? odata_q : '0;
  end else begin : g_direct
    assign pop_mem    = (cnt_q != '0) && bus.rdrdy;
    assign out_occ_d  = 1'b0;
    assign bus.rdvld  = (cnt_q != '0);
    assign bus.rddata = (cnt_q != '0) ? head_word : '0;
  end

`ifndef SYNTHESIS
  if (EDBG != 0) begin : g_dbg
    // Trace packed pushes and pops
    always_ff @(posedge clk) begin
      if (!rst && push) $display("%s push %h", ID, push_word);
      if (!rst && bus.rdvld && bus.rdrdy) $display("%s pop %h", ID, bus.rddata);
    end
  end
`endif
endmodule

// File: tb/tb_powlib_up_fifo.sv
// Bench for powlib_up_fifo: DUT A (MULT=3, EASYNC=0) and DUT B (MULT=4, EASYNC=1).
// Directed table, hand-written corner sequences and a randomized scoreboard run.
module tb_powlib_up_fifo;
  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned MA    = 3;
  localparam int unsigned MB    = 4;
  localparam int          NWORD = 1200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        wrvld_t [2];
  logic [15:0] wrdata_t[2];
  logic        rdrdy_t [2];
  logic        wrrdy_o [2];
  logic        rdvld_o [2];
  logic [63:0] rddata_o[2];
`ifdef UPFIFO_FLUSH_EN
  logic        flush_t [2];
`endif

  powlib_up_fifo_if #(.W(W), .MULT(MA)) bus_a ();
  powlib_up_fifo_if #(.W(W), .MULT(MB)) bus_b ();

  assign bus_a.wrvld  = wrvld_t[0];
  assign bus_a.wrdata = wrdata_t[0];
  assign bus_a.rdrdy  = rdrdy_t[0];
  assign bus_b.wrvld  = wrvld_t[1];
  assign bus_b.wrdata = wrdata_t[1];
  assign bus_b.rdrdy  = rdrdy_t[1];
`ifdef UPFIFO_FLUSH_EN
  assign bus_a.flush  = flush_t[0];
  assign bus_b.flush  = flush_t[1];
`endif
  assign wrrdy_o[0]  = bus_a.wrrdy;
  assign rdvld_o[0]  = bus_a.rdvld;
  assign rddata_o[0] = 64'(bus_a.rddata);
  assign wrrdy_o[1]  = bus_b.wrrdy;
  assign rdvld_o[1]  = bus_b.rdvld;
  assign rddata_o[1] = 64'(bus_b.rddata);

  powlib_up_fifo #(.W(W), .MULT(MA), .DEPTH(DEPTH), .EASYNC(0)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  powlib_up_fifo #(.W(W), .MULT(MB), .DEPTH(DEPTH), .EASYNC(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct packed {
    logic        vld;
    logic [15:0] data;
    logic        rdy;
    logic        exp_wrrdy;
    logic        exp_rdvld;
    logic [47:0] exp_data;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      wrvld_t[d]  = 1'b0;
      wrdata_t[d] = '0;
      rdrdy_t[d]  = 1'b0;
`ifdef UPFIFO_FLUSH_EN
      flush_t[d]  = 1'b0;
`endif
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: words accepted in order are grouped MULT at a time, first word in the LSBs.
  // A packed word is visible EASYNC edges after the edge that completed it, once at the head.
  task automatic run_rand(input int d, input int unsigned mult, input int unsigned easync);
    logic [63:0] qw[$];
    int          qs[$];
    logic [15:0] part[$];
    logic [63:0] word;
    int          e = 0;
    int          acc_n = 0;
    int          budget = 0;
    logic        exp_rdy, exp_vld;
    do_reset();
    while (budget < 8000) begin
      exp_rdy = (part.size() < int'(mult) - 1) || (qw.size() < int'(DEPTH));
      exp_vld = (qw.size() != 0) && (qs[0] + int'(easync) <= e);
      check($sformatf("rand%0d wrrdy", d), 64'(wrrdy_o[d]), 64'(exp_rdy));
      check($sformatf("rand%0d rdvld", d), 64'(rdvld_o[d]), 64'(exp_vld));
      if (exp_vld) check($sformatf("rand%0d rddata", d), rddata_o[d], qw[0]);
      if (acc_n >= NWORD && qw.size() == 0) break;
      wrvld_t[d]  = (acc_n < NWORD) && ($urandom_range(3) != 0);
      wrdata_t[d] = 16'($urandom);
      rdrdy_t[d]  = (acc_n >= NWORD) || ($urandom_range(9) < ((acc_n < NWORD / 2) ? 2 : 6));
      @(posedge clk);
      e++;
      if (exp_vld && rdrdy_t[d]) begin
        void'(qw.pop_front());
        void'(qs.pop_front());
      end
      if (wrvld_t[d] && exp_rdy) begin
        part.push_back(wrdata_t[d]);
        acc_n++;
        if (part.size() == int'(mult)) begin
          word = '0;
          foreach (part[k]) word |= 64'(part[k]) << (16 * k);
          qw.push_back(word);
          qs.push_back(e);
          part.delete();
        end
      end
      @(negedge clk);
      budget++;
    end
    check($sformatf("rand%0d words accepted", d), 64'(acc_n), 64'(NWORD));
    check($sformatf("rand%0d drained", d), 64'(qw.size()), 64'd0);
    idle_inputs();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic rdy_s;
    rst = 1'b1;
    idle_inputs();

    tbl[0]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 48'h0};
    tbl[1]  = '{1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 48'h0};
    tbl[2]  = '{1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, 48'h0003_0002_0001};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 48'h0};
    tbl[4]  = '{1'b1, 16'h000a, 1'b0, 1'b1, 1'b0, 48'h0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 48'h0};
    tbl[6]  = '{1'b1, 16'h000b, 1'b0, 1'b1, 1'b0, 48'h0};
    tbl[7]  = '{1'b1, 16'h000c, 1'b0, 1'b1, 1'b1, 48'h000c_000b_000a};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 48'h000c_000b_000a};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 48'h0};
    tbl[10] = '{1'b1, 16'h0011, 1'b0, 1'b1, 1'b0, 48'h0};
    tbl[11] = '{1'b1, 16'h0012, 1'b0, 1'b1, 1'b0, 48'h0};
    tbl[12] = '{1'b1, 16'h0013, 1'b0, 1'b1, 1'b1, 48'h0013_0012_0011};
    tbl[13] = '{1'b1, 16'h0021, 1'b0, 1'b1, 1'b1, 48'h0013_0012_0011};
    tbl[14] = '{1'b1, 16'h0022, 1'b0, 1'b1, 1'b1, 48'h0013_0012_0011};
    tbl[15] = '{1'b1, 16'h0023, 1'b1, 1'b1, 1'b1, 48'h0023_0022_0021};
    tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 48'h0};

    do_reset();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset%0d wrrdy", d), 64'(wrrdy_o[d]), 64'd1);
      check($sformatf("reset%0d rdvld", d), 64'(rdvld_o[d]), 64'd0);
      check($sformatf("reset%0d rddata", d), rddata_o[d], 64'd0);
    end

    // Table vectors on DUT A
    for (int i = 0; i < 17; i++) begin
      wrvld_t[0]  = tbl[i].vld;
      wrdata_t[0] = tbl[i].data;
      rdrdy_t[0]  = tbl[i].rdy;
      step();
      check($sformatf("vec%0d wrrdy", i), 64'(wrrdy_o[0]), 64'(tbl[i].exp_wrrdy));
      check($sformatf("vec%0d rdvld", i), 64'(rdvld_o[0]), 64'(tbl[i].exp_rdvld));
      if (tbl[i].exp_rdvld) check($sformatf("vec%0d rddata", i), rddata_o[0], 64'(tbl[i].exp_data));
    end

    // Fill DUT A with the consumer stalled: 8 full words plus 2 partial
    do_reset();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      wrvld_t[0]  = 1'b1;
      wrdata_t[0] = 16'(n + 1);
      rdy_s       = wrrdy_o[0];
      @(posedge clk);
      if (rdy_s) n++;
      @(negedge clk);
    end
    check("fill accepted", 64'(n), 64'd26);
    check("fill wrrdy", 64'(wrrdy_o[0]), 64'd0);
    check("fill head", rddata_o[0], 64'h0003_0002_0001);
    wrvld_t[0] = 1'b0;
    rdrdy_t[0] = 1'b1;
    step();
    rdrdy_t[0] = 1'b0;
    check("after pop wrrdy", 64'(wrrdy_o[0]), 64'd1);
    check("after pop head", rddata_o[0], 64'h0006_0005_0004);

    // DUT B: registered output adds one cycle after the completing edge
    do_reset();
    rdrdy_t[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wrvld_t[1]  = 1'b1;
      wrdata_t[1] = 16'(k + 1);
      step();
    end
    wrvld_t[1] = 1'b0;
    check("easync edge N rdvld", 64'(rdvld_o[1]), 64'd0);
    step();
    check("easync edge N+1 rdvld", 64'(rdvld_o[1]), 64'd1);
    check("easync rddata", rddata_o[1], 64'h0004_0003_0002_0001);
    step();
    check("easync popped rdvld", 64'(rdvld_o[1]), 64'd0);

    // Mid-accumulation reset on DUT A discards the partial word
    do_reset();
    wrvld_t[0]  = 1'b1;
    wrdata_t[0] = 16'h0aaa;
    step();
    wrdata_t[0] = 16'h0bbb;
    step();
    wrvld_t[0] = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    check("midrst wrrdy", 64'(wrrdy_o[0]), 64'd1);
    check("midrst rdvld", 64'(rdvld_o[0]), 64'd0);
    check("midrst rddata", rddata_o[0], 64'd0);
    @(negedge clk);
    wrvld_t[0]  = 1'b1;
    wrdata_t[0] = 16'h1234;
    step();
    wrdata_t[0] = 16'h5678;
    step();
    check("midrst partial rdvld", 64'(rdvld_o[0]), 64'd0);
    wrdata_t[0] = 16'h9abc;
    step();
    wrvld_t[0] = 1'b0;
    check("midrst word rdvld", 64'(rdvld_o[0]), 64'd1);
    check("midrst word rddata", rddata_o[0], 64'h9abc_5678_1234);
    rdrdy_t[0] = 1'b1;
    step();
    check("midrst single word", 64'(rdvld_o[0]), 64'd0);
    rdrdy_t[0] = 1'b0;

`ifdef UPFIFO_FLUSH_EN
    // Flush of a partial word zero-fills the unfilled upper words
    wrvld_t[0]  = 1'b1;
    wrdata_t[0] = 16'h0f01;
    step();
    wrdata_t[0] = 16'h0f02;
    step();
    wrvld_t[0] = 1'b0;
    flush_t[0] = 1'b1;
    step();
    check("flush rdvld", 64'(rdvld_o[0]), 64'd1);
    check("flush rddata", rddata_o[0], 64'h0000_0f02_0f01);
    rdrdy_t[0] = 1'b1;
    step();
    flush_t[0] = 1'b0;
    rdrdy_t[0] = 1'b0;
    check("flush idle ignored", 64'(rdvld_o[0]), 64'd0);
    wrvld_t[0]  = 1'b1;
    wrdata_t[0] = 16'h0f03;
    step();
    wrdata_t[0] = 16'h0f04;
    flush_t[0]  = 1'b1;
    step();
    wrvld_t[0] = 1'b0;
    flush_t[0] = 1'b0;
    check("flush with word rddata", rddata_o[0], 64'h0000_0f04_0f03);
`endif

    run_rand(0, MA, 0);
    run_rand(1, MB, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
